// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and write-request type for the scoreboarded register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 16;
  localparam int REGFILE_NUM_REGS = 16;
  localparam int REGFILE_HI_REG   = 0;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  localparam int REGFILE_AW = addr_w(REGFILE_NUM_REGS);

  typedef struct packed {
    logic                        en;
    logic                        hi_en;
    logic [REGFILE_AW-1:0]       addr;
    logic [2*REGFILE_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard: reserve sets, writeback releases, reserve wins on a same-cycle clash.
// State updates one cycle after the request; halt_i freezes everything; no backpressure.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int  NUM_REGS = REGFILE_NUM_REGS,
  parameter int  HI_REG   = REGFILE_HI_REG,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt_i,
  input  logic                rel_en_i,
  input  logic                rel_hi_i,
  input  logic [AW-1:0]       rel_addr_i,
  input  logic                rsv_en_i,
  input  logic [AW-1:0]       rsv_addr_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                any_busy_o,
  output logic                err_dbl_rsv_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] rel_vec, rsv_vec;
  logic                err_q, err_d;

  always_comb begin
    rel_vec = '0;
    rsv_vec = '0;
    if (!halt_i && rel_en_i) begin
      rel_vec[rel_addr_i] = 1'b1;
      if (rel_hi_i) rel_vec[HI_REG] = 1'b1;
    end
    if (!halt_i && rsv_en_i) rsv_vec[rsv_addr_i] = 1'b1;
    busy_d = (busy_q & ~rel_vec) | rsv_vec;
    // A reserve that coincides with the release of the same register is a fresh producer, not an error.
    err_d  = err_q | (|(rsv_vec & busy_q & ~rel_vec));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_o        = busy_q;
  assign any_busy_o    = |busy_q;
  assign err_dbl_rsv_o = err_q;

endmodule

// File: rtl/regfile_scoreboard_bank.sv
// Multi-port register file with double-width write and busy scoreboard; reads are combinational, writes land at the posedge.
// REGFILE_BYPASS_EN forwards same-cycle write data (and masks rd_busy) onto matching read ports.
module regfile_scoreboard_bank
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = REGFILE_DATA_W,
  parameter int  NUM_REGS = REGFILE_NUM_REGS,
  parameter int  NUM_RD   = 2,
  parameter int  HI_REG   = REGFILE_HI_REG,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt_sys,
  input  logic [NUM_RD*AW-1:0]     ra,
  input  logic                     r0_read,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     write_en,
  input  logic                     R0_en,
  input  logic [AW-1:0]            write_address,
  input  logic [2*DATA_W-1:0]      write_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     any_busy,
  output logic                     err_dbl_rsv
);

  localparam logic [AW-1:0] HI_A = AW'(HI_REG);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [AW-1:0]       eff_addr [NUM_RD];
  logic                wr_fire;
  logic [DATA_W-1:0]   wr_lo, wr_hi;

  assign wr_fire        = write_en & ~halt_sys;
  assign {wr_hi, wr_lo} = write_data;

  // Low word is written last so it wins when write_address == HI_REG.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      if (R0_en) regs_q[HI_REG] <= wr_hi;
      regs_q[write_address] <= wr_lo;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      eff_addr[k] = ra[k*AW +: AW];
      if (k == 1 && r0_read) eff_addr[k] = HI_A;
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd[k*DATA_W +: DATA_W] = regs_q[eff_addr[k]];
      rd_busy[k]             = busy[eff_addr[k]];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && eff_addr[k] == write_address) begin
        rd[k*DATA_W +: DATA_W] = wr_lo;
        rd_busy[k]             = 1'b0;
      end else if (wr_fire && R0_en && eff_addr[k] == HI_A) begin
        rd[k*DATA_W +: DATA_W] = wr_hi;
        rd_busy[k]             = 1'b0;
      end
`endif
    end
  end

  regfile_busy_tracker #(
    .NUM_REGS (NUM_REGS),
    .HI_REG   (HI_REG)
  ) u_busy (
    .clk           (clk),
    .rst           (rst),
    .halt_i        (halt_sys),
    .rel_en_i      (write_en),
    .rel_hi_i      (R0_en),
    .rel_addr_i    (write_address),
    .rsv_en_i      (rsv_en),
    .rsv_addr_i    (rsv_addr),
    .busy_o        (busy),
    .any_busy_o    (any_busy),
    .err_dbl_rsv_o (err_dbl_rsv)
  );

endmodule

// File: doc/regfile_scoreboard_bank.md
Name: regfile_scoreboard_bank

Overview:
Parametrised successor to the 16x16 register file. It adds:
- N read ports, configurable width and depth.
- A generalised double-width write: the high word goes to a selectable register.
- A per-register busy scoreboard that tells the decode/hazard logic which reads are stale.

It sits between decode and writeback and is written once per cycle.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, register count; power of two, at least 2.
- NUM_RD, 2, read port count; at least 2 (port 1 is the branch port).
- HI_REG, 0, index that receives the high word on a double write.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high; clears all state
- halt_sys  in  1  freeze: no write, reserve or release takes effect
- ra  in  NUM_RD*AW  flattened read addresses; AW = clog2(NUM_REGS); port k at bits [k*AW +: AW]
- r0_read  in  1  forces read port 1 to return register HI_REG
- rd  out  NUM_RD*DATA_W  flattened read data; port k at bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  per port: the addressed register has a pending writer
- write_en  in  1  writeback strobe
- R0_en  in  1  also write the high word to HI_REG
- write_address  in  AW  writeback destination
- write_data  in  2*DATA_W  {high, low}; low goes to write_address
- rsv_en  in  1  mark rsv_addr busy (producer issued)
- rsv_addr  in  AW  register being reserved
- any_busy  out  1  OR of all busy bits
- err_dbl_rsv  out  1  sticky: a reserve hit an already-busy register

Behaviour:
- Reset (asynchronous, active-high):
  - All registers go to 0.
  - All busy bits, any_busy and err_dbl_rsv go to 0.
  - rd therefore reads 0; there is no hex preload.
  - Reset mid-write discards the write.
- Reads are combinational, with zero latency:
  - rd[k] = reg[ra[k]].
  - Port 1 returns reg[HI_REG] when r0_read=1.
- Write occurs at the posedge when write_en=1 and halt_sys=0:
  - reg[write_address] <= low word.
  - If R0_en=1, reg[HI_REG] <= high word as well.
  - If write_address==HI_REG with R0_en=1, the low word wins.
- Release: a write (per the rule above) clears busy[write_address]. With R0_en=1 it also clears busy[HI_REG].
- Reserve: at the posedge with rsv_en=1 and halt_sys=0, busy[rsv_addr] <= 1.
  - If that bit was already 1, err_dbl_rsv <= 1. The flag stays set until rst.
- Same-cycle reserve and release to the same register: the reserve wins and busy stays 1 (new producer). This case does not set err_dbl_rsv.
- rd_busy[k] = busy[effective read address of port k].
  - A same-cycle release of that address masks rd_busy to 0 only when bypass is enabled.
- halt_sys=1 holds every register, busy bit and error flag. Reads stay live.
- Width/address rules:
  - write_data is split exactly into DATA_W halves.
  - Addresses are full AW bits, so there is no out-of-range case.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - A read whose effective address matches an active write returns the incoming data that cycle. The address is write_address, or HI_REG when R0_en=1.
  - Low word takes priority when both match.
  - rd_busy is masked for a released register.
- Undefined:
  - Reads return the pre-write contents.
  - rd_busy reflects the registered busy bit only.
  - Decode must stall one extra cycle.

Decomposition:
- Package regfile_pkg:
  - function addr_w(n) returning clog2.
  - Default constants REGFILE_DATA_W=16, REGFILE_NUM_REGS=16, REGFILE_HI_REG=0.
  - typedef of a write-request struct {en, hi_en, addr, data}.
- One sub-module, regfile_busy_tracker:
  - Owns the busy vector, the reserve/release priority, err_dbl_rsv and any_busy.
  - The top level holds the storage array, read muxes and bypass.

Test Plan:
- Reset: assert rst mid-write of 0xBEEF to R3 -> all rd=0, rd_busy=0, err_dbl_rsv=0. Deassert, then read R3 -> 0x0000.
- Double write: write_data=0x1234_ABCD, write_address=5, R0_en=1 -> next cycle R5=0xABCD, R0=0x1234. Port 1 with r0_read=1 -> 0x1234.
- Collision: write_address=0, R0_en=1, data 0x1111_2222 -> R0=0x2222.
- Scoreboard:
  - Reserve R7 -> rd_busy=1 for ra=7 and any_busy=1.
  - Write R7=0x00FF -> busy clears next cycle.
  - Reserve R7 twice without a write -> err_dbl_rsv=1, still 1 after 10 cycles.
  - Reserve and write R7 in the same cycle -> busy stays 1 and err_dbl_rsv stays 0.
- Halt: halt_sys=1 with write R2=0x5555 and reserve R4 -> R2 unchanged and busy[4]=0. Reads still track ra.
- Bypass (REGFILE_BYPASS_EN defined): write R9=0x0A0A with ra0=9 in the same cycle -> rd0=0x0A0A and rd_busy0=0. Without the macro -> old value, and rd_busy0 equals busy[9].
